fp_normalize_round: RTL

- Post-adder stage of the floating-point add/sub datapath; the counterpart of the pre-add mantissa alignment shifter.
- Accepts the raw extended mantissa sum (carry, hidden, fraction, guard/round/sticky) with the larger biased exponent and the result sign.
- Normalizes iteratively (one left shift per cycle), rounds to nearest-even and packs the IEEE 754 result fields.
- Uses valid/ready handshakes on both sides.

---
 rtl/fp_normalize_round.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fp_normalize_round.sv
// Post-adder normalize/round stage of the floating-point add/sub datapath.
// Takes the raw extended mantissa sum (carry, hidden, fraction, G/R/S), the
// larger biased exponent and the result sign. It normalizes with one left
// shift per cycle, rounds to nearest-even and packs the IEEE 754 fields.
// Both sides use valid/ready handshakes, and only one operand is in flight.
module fp_normalize_round #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int EXP_WIDTH      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MANTISSA_WIDTH+4:0]   sum_mantissa,
    input  logic [EXP_WIDTH-1:0]        exp_in,
    input  logic                        sign_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        sign_out,
    output logic [EXP_WIDTH-1:0]        exp_out,
    output logic [MANTISSA_WIDTH-1:0]   frac_out,
    output logic                        overflow,
    output logic                        underflow,
    output logic                        inexact
);

    localparam int W  = MANTISSA_WIDTH + 5;   // working mantissa width
    localparam int CB = MANTISSA_WIDTH + 4;   // carry bit index
    localparam int HB = MANTISSA_WIDTH + 3;   // hidden bit index

    // The working exponent has one extra bit, so carry increments cannot wrap.
    localparam logic [EXP_WIDTH:0] EXP_ONE = {{EXP_WIDTH{1'b0}}, 1'b1};
    localparam logic [EXP_WIDTH:0] EXP_MAX = {1'b0, {EXP_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t                  state;
    logic [W-1:0]            mant;
    logic [EXP_WIDTH:0]      exp;
    logic                    sign;

    logic                    round_up;
    logic                    round_inexact;
    logic [MANTISSA_WIDTH+1:0] rounded_sig;   // {carry, hidden, fraction} after the increment
    logic [MANTISSA_WIDTH-1:0] round_frac;
    logic [EXP_WIDTH:0]      round_exp;
    logic                    round_ovf;

    // Round-to-nearest-even on the normalized mantissa, with carry-out renormalization.
    // NOTE: every output of this block gets a value on every path, so no latch is inferred.
    always_comb begin
        round_up      = mant[2] & (mant[3] | mant[1] | mant[0]);
        round_inexact = mant[2] | mant[1] | mant[0];
        rounded_sig   = {1'b0, mant[HB:3]} + {{(MANTISSA_WIDTH+1){1'b0}}, round_up};
        if (rounded_sig[MANTISSA_WIDTH+1]) begin
            round_frac = rounded_sig[MANTISSA_WIDTH:1];
            round_exp  = exp + EXP_ONE;
        end else begin
            round_frac = rounded_sig[MANTISSA_WIDTH-1:0];
            round_exp  = exp;
        end
        round_ovf = (round_exp >= EXP_MAX);
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sign_out  <= 1'b0;
            exp_out   <= '0;
            frac_out  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
            mant      <= '0;
            exp       <= '0;
            sign      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mant     <= sum_mantissa;
                        exp      <= {1'b0, exp_in};
                        sign     <= sign_in;
                        in_ready <= 1'b0;
                        state    <= CHECK;
                    end
                end

                CHECK: begin
                    if (mant == '0) begin
                        // An exact zero keeps the sign and raises no flags.
                        sign_out  <= sign;
                        exp_out   <= '0;
                        frac_out  <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (mant[CB]) begin
                        // A carry out of the add is handled with one right shift. The bit
                        // shifted out (the old R) is folded into sticky.
                        mant  <= {1'b0, mant[CB:2], mant[1] | mant[0]};
                        exp   <= exp + EXP_ONE;
                        state <= ROUND;
                    end else if (mant[HB]) begin
                        state <= ROUND;
                    end else if (exp == '0) begin
                        sign_out  <= sign;
                        exp_out   <= '0;
                        frac_out  <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                        inexact   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= NORM;
                    end
                end

                NORM: begin
                    if (exp == EXP_ONE) begin
                        // The exponent cannot go lower, so the result is flushed to zero.
                        sign_out  <= sign;
                        exp_out   <= '0;
                        frac_out  <= '0;
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                        inexact   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mant <= mant << 1;
                        exp  <= exp - EXP_ONE;
                        if (mant[HB-1]) begin
                            state <= ROUND;
                        end
                    end
                end

                ROUND: begin
                    sign_out  <= sign;
                    underflow <= 1'b0;
                    inexact   <= round_inexact;
                    out_valid <= 1'b1;
                    if (round_ovf) begin
                        exp_out  <= {EXP_WIDTH{1'b1}};
                        frac_out <= '0;
                        overflow <= 1'b1;
                    end else begin
                        exp_out  <= round_exp[EXP_WIDTH-1:0];
                        frac_out <= round_frac;
                        overflow <= 1'b0;
                    end
                    state <= DONE;
                end

                DONE: begin
                    // Hold the result until it is taken. A new operand is accepted from IDLE only.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
